// File: rtl/iscas_c17_if.sv
// Signal bundle for the c17 fault-simulation golden block: primary inputs,
// fault-config bus, and the combinational plus registered primary outputs.
`timescale 1ns/1ps

interface iscas_c17_if;
  // Primary inputs, vector bit order N1 = bit 0 ... N7 = bit 4
  logic       N1;
  logic       N2;
  logic       N3;
  logic       N6;
  logic       N7;

  // Single stuck-at fault configuration
  logic       cfg_we;
  logic       fault_en;
  logic [3:0] fault_site;
  logic       fault_val;

  // Primary outputs, combinational and registered
  logic       N22;
  logic       N23;
  logic       N22_q;
  logic       N23_q;

  // The side that drives vectors and configures faults
  modport master (
    output N1, N2, N3, N6, N7,
    output cfg_we, fault_en, fault_site, fault_val,
    input  N22, N23, N22_q, N23_q
  );

  // The c17 circuit itself
  modport slave (
    input  N1, N2, N3, N6, N7,
    input  cfg_we, fault_en, fault_site, fault_val,
    output N22, N23, N22_q, N23_q
  );
endinterface

// File: rtl/iscas_c17.sv
// ISCAS-85 c17 benchmark with a single stuck-at fault-injection register.
// Six 2-input NANDs form the combinational core. Any one of the eleven nets
// can be forced to a stuck value selected by a clocked config register, and
// both primary outputs are also provided as registered copies.
`timescale 1ns/1ps

module iscas_c17 (
  input  logic       clk,
  input  logic       rst_n,
  iscas_c17_if.slave bus
);

  // Net indices used by the fault-site encoding; 11..15 select nothing
  localparam logic [3:0] SITE_N1  = 4'd0;
  localparam logic [3:0] SITE_N2  = 4'd1;
  localparam logic [3:0] SITE_N3  = 4'd2;
  localparam logic [3:0] SITE_N6  = 4'd3;
  localparam logic [3:0] SITE_N7  = 4'd4;
  localparam logic [3:0] SITE_N10 = 4'd5;
  localparam logic [3:0] SITE_N11 = 4'd6;
  localparam logic [3:0] SITE_N16 = 4'd7;
  localparam logic [3:0] SITE_N19 = 4'd8;
  localparam logic [3:0] SITE_N22 = 4'd9;
  localparam logic [3:0] SITE_N23 = 4'd10;

  // Fault configuration state
  logic       faultEn_q;
  logic       faultEn_d;
  logic [3:0] faultSite_q;
  logic [3:0] faultSite_d;
  logic       faultVal_q;
  logic       faultVal_d;

  // Registered output copies
  logic       outN22_q;
  logic       outN22_d;
  logic       outN23_q;
  logic       outN23_d;

  // One-hot "this net is faulted" flags, one per net index
  logic [10:0] siteHit;

  // Possibly-faulted versions of every net in the circuit
  logic n1;
  logic n2;
  logic n3;
  logic n6;
  logic n7;
  logic n10;
  logic n11;
  logic n16;
  logic n19;
  logic n22;
  logic n23;

  // Replace a net's fault-free value by the stuck value when it is the site
  function automatic logic forceNet(input logic hit, input logic good,
                                    input logic stuckVal);
    return hit ? stuckVal : good;
  endfunction

  // Config register next state: all three fields load together or hold
  always_comb begin
    faultEn_d   = faultEn_q;
    faultSite_d = faultSite_q;
    faultVal_d  = faultVal_q;
    if (bus.cfg_we) begin
      faultEn_d   = bus.fault_en;
      faultSite_d = bus.fault_site;
      faultVal_d  = bus.fault_val;
    end
  end

  // Config register; reset clears any active fault without waiting for clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      faultEn_q   <= 1'b0;
      faultSite_q <= 4'd0;
      faultVal_q  <= 1'b0;
    end else begin
      faultEn_q   <= faultEn_d;
      faultSite_q <= faultSite_d;
      faultVal_q  <= faultVal_d;
    end
  end

  // Decode the registered site into a one-hot flag; unused codes hit nothing
  always_comb begin
    siteHit = '0;
    if (faultEn_q) begin
      case (faultSite_q)
        SITE_N1:  siteHit[0]  = 1'b1;
        SITE_N2:  siteHit[1]  = 1'b1;
        SITE_N3:  siteHit[2]  = 1'b1;
        SITE_N6:  siteHit[3]  = 1'b1;
        SITE_N7:  siteHit[4]  = 1'b1;
        SITE_N10: siteHit[5]  = 1'b1;
        SITE_N11: siteHit[6]  = 1'b1;
        SITE_N16: siteHit[7]  = 1'b1;
        SITE_N19: siteHit[8]  = 1'b1;
        SITE_N22: siteHit[9]  = 1'b1;
        SITE_N23: siteHit[10] = 1'b1;
        default:  siteHit     = '0;
      endcase
    end
  end

  // NAND network; each stem is forced once so every fanout sees the fault
  always_comb begin
    n1  = forceNet(siteHit[0],  bus.N1, faultVal_q);
    n2  = forceNet(siteHit[1],  bus.N2, faultVal_q);
    n3  = forceNet(siteHit[2],  bus.N3, faultVal_q);
    n6  = forceNet(siteHit[3],  bus.N6, faultVal_q);
    n7  = forceNet(siteHit[4],  bus.N7, faultVal_q);
    n10 = forceNet(siteHit[5],  ~(n1 & n3),   faultVal_q);
    n11 = forceNet(siteHit[6],  ~(n3 & n6),   faultVal_q);
    n16 = forceNet(siteHit[7],  ~(n2 & n11),  faultVal_q);
    n19 = forceNet(siteHit[8],  ~(n11 & n7),  faultVal_q);
    n22 = forceNet(siteHit[9],  ~(n10 & n16), faultVal_q);
    n23 = forceNet(siteHit[10], ~(n16 & n19), faultVal_q);
  end

  // Output copies always follow the current (possibly faulted) outputs
  always_comb begin
    outN22_d = n22;
    outN23_d = n23;
  end

  // Output copy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outN22_q <= 1'b0;
      outN23_q <= 1'b0;
    end else begin
      outN22_q <= outN22_d;
      outN23_q <= outN23_d;
    end
  end

  assign bus.N22   = n22;
  assign bus.N23   = n23;
  assign bus.N22_q = outN22_q;
  assign bus.N23_q = outN23_q;

endmodule

// File: tb/tb_iscas_c17.sv
// Self-checking bench for iscas_c17: directed vector table, exhaustive
// fault-free sweep, fault table, unused-site sweep and reset corner cases.
`timescale 1ns/1ps

module tb_iscas_c17;

  logic clk;
  logic rst_n;
  int   testsRun;
  int   testsFailed;

  iscas_c17_if bus ();

  iscas_c17 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 ns period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] vec;
    logic [1:0] expOut;
  } vecRec_t;

  typedef struct {
    logic [3:0] site;
    logic       val;
    logic [4:0] vec;
    logic [1:0] expOut;
  } faultRec_t;

  vecRec_t   vecTable[11];
  faultRec_t faultTable[5];

  // Reference c17 straight from the gate equations
  function automatic logic [1:0] goldenC17(input logic [4:0] v);
    logic a10, a11, a16, a19, a22, a23;
    a10 = ~(v[0] & v[2]);
    a11 = ~(v[2] & v[3]);
    a16 = ~(v[1] & a11);
    a19 = ~(a11 & v[4]);
    a22 = ~(a10 & a16);
    a23 = ~(a16 & a19);
    return {a23, a22};
  endfunction

  task automatic applyStimulus(input logic [4:0] v);
    bus.N1 = v[0];
    bus.N2 = v[1];
    bus.N3 = v[2];
    bus.N6 = v[3];
    bus.N7 = v[4];
  endtask

  // Drive config at a falling edge and let the next rising edge capture it
  task automatic writeConfig(input logic en, input logic [3:0] site,
                             input logic val);
    @(negedge clk);
    bus.cfg_we     = 1'b1;
    bus.fault_en   = en;
    bus.fault_site = site;
    bus.fault_val  = val;
    @(posedge clk);
    #1;
    bus.cfg_we     = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] actual,
                             input logic [1:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;

    // Hand-computed {N23,N22} for vectors {N7,N6,N3,N2,N1}
    vecTable[0]  = '{5'b00000, 2'b00};
    vecTable[1]  = '{5'b11111, 2'b01};
    vecTable[2]  = '{5'b00010, 2'b11};
    vecTable[3]  = '{5'b10000, 2'b10};
    vecTable[4]  = '{5'b00101, 2'b01};
    vecTable[5]  = '{5'b01110, 2'b00};
    vecTable[6]  = '{5'b11010, 2'b11};
    vecTable[7]  = '{5'b10111, 2'b11};
    vecTable[8]  = '{5'b01000, 2'b00};
    vecTable[9]  = '{5'b11100, 2'b00};
    vecTable[10] = '{5'b10110, 2'b11};

    // Hand-computed faulted outputs (site, stuck value, vector, {N23,N22})
    faultTable[0] = '{4'd6,  1'b0, 5'b00010, 2'b00};
    faultTable[1] = '{4'd10, 1'b0, 5'b00010, 2'b01};
    faultTable[2] = '{4'd2,  1'b1, 5'b01011, 2'b01};
    faultTable[3] = '{4'd8,  1'b0, 5'b00000, 2'b10};
    faultTable[4] = '{4'd4,  1'b1, 5'b00000, 2'b10};

    rst_n          = 1'b0;
    bus.cfg_we     = 1'b0;
    bus.fault_en   = 1'b0;
    bus.fault_site = 4'd0;
    bus.fault_val  = 1'b0;
    applyStimulus(5'b00010);
    #1;
    checkOutput("reset_regs", {bus.N23_q, bus.N22_q}, 2'b00);
    checkOutput("reset_comb", {bus.N23, bus.N22}, 2'b11);
    #20;
    rst_n = 1'b1;

    // Directed fault-free table
    foreach (vecTable[i]) begin
      applyStimulus(vecTable[i].vec);
      #1;
      checkOutput($sformatf("vec_%05b", vecTable[i].vec),
                  {bus.N23, bus.N22}, vecTable[i].expOut);
    end

    // Exhaustive fault-free sweep, one vector per time unit
    for (int v = 0; v < 32; v++) begin
      applyStimulus(v[4:0]);
      #1;
      checkOutput($sformatf("exh_%0d", v), {bus.N23, bus.N22},
                  goldenC17(v[4:0]));
    end

    // Stuck-at-0 on N16 with inputs all zero; register copy lags one edge
    applyStimulus(5'b00000);
    writeConfig(1'b1, 4'd7, 1'b0);
    checkOutput("n16_sa0_comb", {bus.N23, bus.N22}, 2'b11);
    checkOutput("n16_sa0_q_pre", {bus.N23_q, bus.N22_q}, 2'b00);
    @(posedge clk);
    #1;
    checkOutput("n16_sa0_q_post", {bus.N23_q, bus.N22_q}, 2'b11);

    // With cfg_we low the config holds even if the fields change
    @(negedge clk);
    bus.fault_en = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("cfg_hold", {bus.N23, bus.N22}, 2'b11);

    // Fault table: one config write then a combinational check per entry
    foreach (faultTable[i]) begin
      applyStimulus(faultTable[i].vec);
      writeConfig(1'b1, faultTable[i].site, faultTable[i].val);
      checkOutput($sformatf("fault_site%0d_sa%0d", faultTable[i].site,
                            faultTable[i].val),
                  {bus.N23, bus.N22}, faultTable[i].expOut);
    end

    // Unused site: every vector must look fault-free
    writeConfig(1'b1, 4'd12, 1'b1);
    for (int v = 0; v < 32; v++) begin
      applyStimulus(v[4:0]);
      #1;
      checkOutput($sformatf("site12_%0d", v), {bus.N23, bus.N22},
                  goldenC17(v[4:0]));
    end

    // N22 stuck-at-1, then asynchronous reset between clock edges
    applyStimulus(5'b00000);
    writeConfig(1'b1, 4'd9, 1'b1);
    checkOutput("n22_sa1_comb", {bus.N23, bus.N22}, 2'b01);
    @(posedge clk);
    #1;
    checkOutput("n22_sa1_q", {bus.N23_q, bus.N22_q}, 2'b01);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_comb", {bus.N23, bus.N22}, 2'b00);
    checkOutput("async_rst_q", {bus.N23_q, bus.N22_q}, 2'b00);

    // Config writes are ignored while reset is held across an edge
    bus.cfg_we     = 1'b1;
    bus.fault_en   = 1'b1;
    bus.fault_site = 4'd9;
    bus.fault_val  = 1'b1;
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
    checkOutput("rst_ignores_cfg", {bus.N23, bus.N22}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_comb", {bus.N23, bus.N22}, 2'b00);
    checkOutput("post_rst_q", {bus.N23_q, bus.N22_q}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/iscas_c17.md
# iscas_c17

ISCAS-85 c17 benchmark: five primary inputs, two primary outputs, six 2-input NAND gates. The block is the golden circuit for the deductive fault simulator.

- The primary outputs are purely combinational, so any input vector is valid after propagation delay.
- A clocked single stuck-at fault-injection register and registered output copies support fault-simulation cross-checks.
- Fault-free, the block is a drop-in equivalent of the standard c17 netlist.

## Interface
- No parameters.
- clk  input  1  clock; used only by the fault-config and output registers.
- rst_n  input  1  asynchronous active-low reset.
- N1  input  1  primary input (vector bit 0).
- N2  input  1  primary input (vector bit 1).
- N3  input  1  primary input (vector bit 2).
- N6  input  1  primary input (vector bit 3).
- N7  input  1  primary input (vector bit 4).
- cfg_we  input  1  fault-config write enable, sampled on rising clk.
- fault_en  input  1  enable the injected fault.
- fault_site  input  4  net index to fault (encoding below).
- fault_val  input  1  stuck-at value.
- N22  output  1  primary output (vector bit 0), combinational.
- N23  output  1  primary output (vector bit 1), combinational.
- N22_q  output  1  N22 registered on rising clk.
- N23_q  output  1  N23 registered on rising clk.

## Operation
- Gate equations (fault-free):
  - N10 = ~(N1 & N3)
  - N11 = ~(N3 & N6)
  - N16 = ~(N2 & N11)
  - N19 = ~(N11 & N7)
  - N22 = ~(N10 & N16)
  - N23 = ~(N16 & N19)
- Net index encoding: 0 N1, 1 N2, 2 N3, 3 N6, 4 N7, 5 N10, 6 N11, 7 N16, 8 N19, 9 N22, 10 N23. Indices 11–15 inject nothing.
- Fault model: when the registered fault_en is 1, the selected net is forced to the registered fault_val.
  - The stem fault applies to every fanout of the net.
  - A faulted primary input affects all gates it feeds.
  - A faulted output forces the port itself.
- At most one fault is active at a time (single stuck-at).
- Config register: on rising clk with cfg_we=1, capture fault_en, fault_site and fault_val together. With cfg_we=0, hold.
- Output registers: N22_q/N23_q load the current (possibly faulted) N22/N23 every rising clk.
- No other state. There is no combinational path from cfg inputs to N22/N23 except through the config register.

## Timing
- N22/N23: zero-cycle combinational latency from N1..N7. Settled values are valid within one simulation time unit of an input change.
- N22_q/N23_q: one cycle latency.
- Fault config takes effect on N22/N23 immediately after the capturing clk edge. It takes effect on N22_q/N23_q one edge later.
- Reset, asynchronous on rst_n=0, independent of clk:
  - fault_en=0, fault_site=0, fault_val=0.
  - N22_q=0, N23_q=0.
  - N22/N23 immediately revert to fault-free values.
- Reset mid-operation clears any active fault at once. cfg_we is ignored while rst_n=0.
- Simultaneous cfg_we and input change at a clock edge: the new config applies to the post-edge inputs. N22_q/N23_q capture the pre-edge values.

## Test plan
- Reset, no fault, inputs {N7,N6,N3,N2,N1}=00000 -> {N23,N22}=00; =11111 -> 01; =00010 -> 11; =10000 -> 10.
- Exhaustive: apply all 32 vectors at one per time unit, fault-free -> each {N23,N22} matches the golden equations (vector bit order N1 = bit 0 ... N7 = bit 4).
- Fault inject: inputs 00000, cfg_we with fault_en=1, site=7 (N16), val=0 -> {N23,N22}=11 after the edge. N22_q/N23_q = 11 one cycle later.
- Unused site: fault_en=1, site=12, any val -> outputs identical to fault-free for all 32 vectors.
- Async reset mid-fault: fault active (site 9, val 1), pulse rst_n low between clock edges -> fault cleared immediately, N22_q=N23_q=0, N22 returns to its fault-free value.
